out_port_arbiter: RTL and testbench

OUT_PORT_ARBITER -- requirements
Module: out_port_arbiter

---
 rtl/out_port_arbiter.sv | 132 +++++++++++++
 tb/tb_out_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : out_port_arbiter
// Purpose  : Round-robin arbiter that pops one input FIFO and hands its flit
//            to the serializer of this router output port.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module out_port_arbiter #(
    parameter int routerid = -1,
    parameter int N_IN     = 5,
    parameter int ITEM_W   = `PAYLOAD_SIZE + `ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_IN-1:0]          req,
    input  logic [N_IN*ITEM_W-1:0]   item_in,
    input  logic                     tx_busy,
    output logic [N_IN-1:0]          grant,
    output logic                     ena,
    output logic [ITEM_W-1:0]        item_out,
    output logic                     active,
    output logic [15:0]              grant_count
);

    localparam int LW = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [LW-1:0]     last_q;
    logic [LW-1:0]     sel_idx;
    logic              sel_found;
    logic              take;
    logic [LW:0]       cand_sum;
    logic [LW-1:0]     cand;
    logic [N_IN-1:0]   sel_onehot;
    logic [ITEM_W-1:0] sel_item;
    logic [N_IN-1:0]   grant_q;
    logic [ITEM_W-1:0] item_q;
    logic [15:0]       count_q;

    // Scan from the farthest offset down to last+1 so the nearest hit wins.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = N_IN; k >= 1; k--) begin
            cand_sum = {1'b0, last_q} + (LW+1)'(k);
            if (cand_sum >= (LW+1)'(N_IN)) begin
                cand_sum = cand_sum - (LW+1)'(N_IN);
            end
            cand = cand_sum[LW-1:0];
            if (req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_onehot = '0;
        sel_item   = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel_idx == LW'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_item      = item_in[i*ITEM_W +: ITEM_W];
            end
        end
    end

    assign take = (state_q == S_IDLE) && !tx_busy && sel_found;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (take)     state_d = S_SEND;
            S_SEND:  if (tx_busy)  state_d = S_DRAIN;
            S_DRAIN: if (!tx_busy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ena    = (state_q == S_SEND);
        active = (state_q != S_IDLE);
    end

    // Datapath only moves on a selection edge; SEND/DRAIN leave it frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= '0;
            item_q  <= '0;
            last_q  <= LW'(N_IN - 1);
            count_q <= '0;
        end else begin
            grant_q <= take ? sel_onehot : '0;
            if (take) begin
                item_q <= sel_item;
                last_q <= sel_idx;
                if (count_q != 16'hFFFF) begin
                    count_q <= count_q + 16'd1;
                end
            end
        end
    end

    assign grant       = grant_q;
    assign item_out    = item_q;
    assign grant_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_out_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_out_port_arbiter
// Purpose  : Randomized self-checking bench for out_port_arbiter against a
//            transaction-level round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_out_port_arbiter;

    localparam int N = 5;
    localparam int W = 12;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] item_in;
    logic           tx_busy;
    logic [N-1:0]   grant;
    logic           ena;
    logic [W-1:0]   item_out;
    logic           active;
    logic [15:0]    grant_count;

    int          checks   = 0;
    int          failures = 0;
    int          m_last;
    logic [15:0] m_cnt;

    out_port_arbiter #(.routerid(7), .N_IN(N), .ITEM_W(W)) dut (
        .clk(clk), .reset(reset), .req(req), .item_in(item_in),
        .tx_busy(tx_busy), .grant(grant), .ena(ena), .item_out(item_out),
        .active(active), .grant_count(grant_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Round robin: first requester at distance 1..N from the previous winner.
    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] rand_items();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = '0; tx_busy = 1'b0; item_in = rand_items();
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        m_last = N - 1;
        m_cnt  = 16'd0;
    endtask

    // One complete flit: selection, SEND for 'hold' extra cycles, 2-cycle busy.
    task automatic send_flit(input logic [N-1:0] r, input int hold, input logic [N*W-1:0] items);
        int w;
        logic [W-1:0] exp_item;
        req = r; item_in = items; tx_busy = 1'b0;
        w = rr_pick(m_last, r);
        exp_item = items[w*W +: W];
        m_last = w;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        @(negedge clk);
        checks++;
        if (grant !== (5'b1 << w)) begin failures++; $display("FAIL grant: got %b expected %b", grant, 5'b1 << w); end
        checks++;
        if (item_out !== exp_item) begin failures++; $display("FAIL item_sel: got %h expected %h", item_out, exp_item); end
        checks++;
        if (ena !== 1'b1 || active !== 1'b1) begin failures++; $display("FAIL send_entry: got ena=%b active=%b expected 1 1", ena, active); end
        checks++;
        if (grant_count !== m_cnt) begin failures++; $display("FAIL grant_count: got %h expected %h", grant_count, m_cnt); end
        item_in = rand_items();
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (grant !== '0 || ena !== 1'b1 || item_out !== exp_item) begin
                failures++;
                $display("FAIL send_hold: got grant=%b ena=%b item=%h expected 0 1 %h", grant, ena, item_out, exp_item);
            end
            item_in = rand_items();
        end
        tx_busy = 1'b1;
        @(negedge clk);
        checks++;
        if (ena !== 1'b0 || active !== 1'b1 || grant !== '0 || item_out !== exp_item) begin
            failures++;
            $display("FAIL drain_entry: got ena=%b active=%b grant=%b item=%h expected 0 1 0 %h", ena, active, grant, item_out, exp_item);
        end
        req = N'($urandom); item_in = rand_items();
        @(negedge clk);
        checks++;
        if (ena !== 1'b0 || active !== 1'b1 || item_out !== exp_item) begin
            failures++;
            $display("FAIL drain_hold: got ena=%b active=%b item=%h expected 0 1 %h", ena, active, item_out, exp_item);
        end
        tx_busy = 1'b0; req = r;
        @(negedge clk);
        checks++;
        if (active !== 1'b0 || ena !== 1'b0 || grant !== '0 || item_out !== exp_item) begin
            failures++;
            $display("FAIL drain_exit: got active=%b ena=%b grant=%b item=%h expected 0 0 0 %h", active, ena, grant, item_out, exp_item);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({grant, ena, active} !== 7'b0 || item_out !== '0 || grant_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: got grant=%b ena=%b active=%b item=%h cnt=%h expected all zero", grant, ena, active, item_out, grant_count);
        end
    endtask

    task automatic test_single();
        logic [N*W-1:0] items;
        do_reset();
        items = rand_items();
        items[2*W +: W] = 12'h0A5;
        send_flit(5'b00100, 4, items);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 6; i++) send_flit(5'b11111, 0, rand_items());
        checks++;
        if (grant_count !== 16'd6) begin failures++; $display("FAIL b2b_count: got %0d expected 6", grant_count); end
    endtask

    task automatic test_busy_idle();
        do_reset();
        tx_busy = 1'b1; req = 5'b00011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (grant !== '0 || ena !== 1'b0 || active !== 1'b0) begin
                failures++;
                $display("FAIL busy_idle: got grant=%b ena=%b active=%b expected 0 0 0", grant, ena, active);
            end
        end
        send_flit(5'b00011, 1, rand_items());
    endtask

    task automatic test_wrap();
        do_reset();
        send_flit(5'b01000, 0, rand_items());
        send_flit(5'b01001, 1, rand_items());
        send_flit(5'b01001, 0, rand_items());
    endtask

    task automatic test_reset_abort();
        do_reset();
        req = 5'b00110; tx_busy = 1'b0; item_in = rand_items();
        @(negedge clk);
        tx_busy = 1'b1;
        @(negedge clk);
        checks++;
        if (active !== 1'b1 || ena !== 1'b0) begin failures++; $display("FAIL abort_drain: got active=%b ena=%b expected 1 0", active, ena); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (active !== 1'b0 || ena !== 1'b0 || grant !== '0 || grant_count !== 16'd0 || item_out !== '0) begin
            failures++;
            $display("FAIL abort_reset: got active=%b ena=%b grant=%b cnt=%h item=%h expected all zero", active, ena, grant, grant_count, item_out);
        end
        reset = 1'b0; tx_busy = 1'b0; m_last = N - 1; m_cnt = 16'd0;
        send_flit(5'b00110, 0, rand_items());
        req = 5'b00001;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== '0 || active !== 1'b0 || item_out !== '0) begin
            failures++;
            $display("FAIL abort_send: got grant=%b active=%b item=%h expected 0 0 0", grant, active, item_out);
        end
        reset = 1'b0; req = '0;
    endtask

    task automatic test_saturate();
        do_reset();
        @(negedge clk);
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) send_flit(N'($urandom_range(1, 31)), 0, rand_items());
        checks++;
        if (grant_count !== 16'hFFFF) begin failures++; $display("FAIL saturate: got %h expected ffff", grant_count); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            send_flit(N'($urandom_range(1, 31)), $urandom_range(0, 3), rand_items());
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; item_in = '0; tx_busy = 1'b0;
        m_last = N - 1; m_cnt = 16'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_idle();
        test_wrap();
        test_reset_abort();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
